// File: rtl/core_inst_queue_pkg.sv
// Shared helpers for the multi-port instruction queue.
package core_inst_queue_pkg;

    localparam int unsigned THERMO_CHECK_W = 32;

    // True when v is a thermometer code grown from bit 0 (0, 1, 3, 7, ...).
    function automatic logic is_thermometer(input logic [THERMO_CHECK_W-1:0] v);
        return ((v + THERMO_CHECK_W'(1)) & v) == '0;
    endfunction

endpackage

// File: rtl/core_lane_compact.sv
// Per-lane rank (prefix popcount of lower lanes) and total popcount of a valid mask.
module core_lane_compact
    import core_inst_queue_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0]                     valid_i,
    output logic [LANES-1:0][$clog2(LANES+1)-1:0] rank_c,
    output logic [$clog2(LANES+1)-1:0]           total_c
);

    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [CNT_W-1:0] acc;

    // Running prefix count: each lane's rank is the number of valid lanes below it.
    always_comb begin
        acc    = '0;
        rank_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rank_c[i] = acc;
            acc       = acc + CNT_W'(valid_i[i]);
        end
        total_c = acc;
    end

endmodule

// File: rtl/core_inst_queue.sv
// Multi-lane in-order instruction queue: WRITE_PORT compacted enqueue lanes,
// READ_PORT head-window dequeue lanes, circular storage of DEPTH entries.
module core_inst_queue
    import core_inst_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WRITE_PORT = 2,
    parameter int unsigned READ_PORT  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_i,
    input  logic [WRITE_PORT-1:0]                 write_valid_i,
    input  logic [WRITE_PORT-1:0][DATA_WIDTH-1:0] write_data_i,
    output logic                                  write_ready_o,
    output logic [READ_PORT-1:0]                  read_valid_o,
    output logic [READ_PORT-1:0][DATA_WIDTH-1:0]  read_data_o,
    input  logic [READ_PORT-1:0]                  read_ready_i,
    output logic [$clog2(DEPTH):0]                count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WCNT_W = $clog2(WRITE_PORT + 1);
    localparam int unsigned RCNT_W = $clog2(READ_PORT + 1);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [WRITE_PORT-1:0][WCNT_W-1:0] wr_rank_c;
    logic [WCNT_W-1:0]                 wr_total_c;
    logic                              wr_en_c;
    logic [READ_PORT-1:0]              rd_take_c;
    logic [RCNT_W-1:0]                 rd_num_c;

    core_lane_compact #(
        .LANES (WRITE_PORT)
    ) u_wr_compact (
        .valid_i (write_valid_i),
        .rank_c  (wr_rank_c),
        .total_c (wr_total_c)
    );

    // Ready depends on registered occupancy only, so a full group always fits.
    assign write_ready_o = (count_q <= CNT_W'(DEPTH - WRITE_PORT));
    assign count_o       = count_q;

    // Head window: lane i shows entry head+i, valid while occupancy exceeds i.
    always_comb begin
        read_valid_o = '0;
        read_data_o  = '0;
        for (int unsigned i = 0; i < READ_PORT; i++) begin
            read_valid_o[i] = (count_q > CNT_W'(i));
            read_data_o[i]  = mem_q[head_q + PTR_W'(i)];
        end
    end

    // Number of entries consumed this cycle (only lanes that are actually valid).
    always_comb begin
        rd_take_c = read_ready_i & read_valid_o;
        rd_num_c  = '0;
        for (int unsigned i = 0; i < READ_PORT; i++) begin
            rd_num_c = rd_num_c + RCNT_W'(rd_take_c[i]);
        end
    end

    // Next-state: compacted writes at tail, head advance, occupancy update; flush clears pointers.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        wr_en_c = write_ready_o && !flush_i && !rst;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en_c) begin
                for (int unsigned i = 0; i < WRITE_PORT; i++) begin
                    if (write_valid_i[i]) begin
                        mem_d[tail_q + PTR_W'(wr_rank_c[i])] = write_data_i[i];
                    end
                end
            end
            tail_d  = tail_q + (wr_en_c ? PTR_W'(wr_total_c) : PTR_W'(0));
            head_d  = head_q + PTR_W'(rd_num_c);
            count_d = count_q + (wr_en_c ? CNT_W'(wr_total_c) : CNT_W'(0)) - CNT_W'(rd_num_c);
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Consumers must present a contiguous-from-lane-0 ready mask.
    a_read_ready_thermo: assert property (@(posedge clk) disable iff (rst)
        is_thermometer(THERMO_CHECK_W'(read_ready_i)));

endmodule
